// File: rtl/lbp_window_sched.sv
// lbp_window_sched: controller that sequences the LBP encoder datapath.
//   It accepts a valid/ready sample stream, drives the datapath strobes and
//   hands each completed window HV to the classifier over valid/ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            run request from system control
//   sample_valid/ready  upstream sample handshake (ready is combinational)
//   shift_en          shift sample memory and load the new sample
//   code_en           compute LBP code and push the sample HV into the window
//   win_latch         capture the bundler output into the window register
//   window_valid/ready  downstream window handshake
//   first_win         current/most recent window is the first since start
//   fill_cnt          codes pushed into the current window
//   window_count      windows handed off since reset (saturating)
//   state_o           FSM state: IDLE=0 WARMUP=1 FILL=2 STEP=3 LATCH=4 EMIT=5
module lbp_window_sched #(
  parameter int unsigned WINDOW_SIZE = 256,
  parameter int unsigned WINDOW_STEP = 128,
  parameter int unsigned LBP_SIZE    = 6,
  parameter int unsigned CNT_W       = $clog2(WINDOW_SIZE + 1),
  parameter int unsigned WCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              shift_en,
  output logic              code_en,
  output logic              win_latch,
  output logic              window_valid,
  input  logic              window_ready,
  output logic              first_win,
  output logic [CNT_W-1:0]  fill_cnt,
  output logic [WCNT_W-1:0] window_count,
  output logic [2:0]        state_o
);

  localparam int unsigned WarmW = (LBP_SIZE > 0) ? $clog2(LBP_SIZE + 1) : 1;

  localparam logic [WarmW-1:0] WarmLast = WarmW'(LBP_SIZE);
  localparam logic [CNT_W-1:0] FillLast = CNT_W'(WINDOW_SIZE);
  localparam logic [CNT_W-1:0] StepLast = CNT_W'(WINDOW_STEP);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWarmup = 3'd1,
    StFill   = 3'd2,
    StStep   = 3'd3,
    StLatch  = 3'd4,
    StEmit   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [WarmW-1:0]    warm_q, warm_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [WCNT_W-1:0]   wcount_q, wcount_d;
  logic                first_q, first_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      warm_q   <= '0;
      fill_q   <= '0;
      wcount_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      fill_q   <= fill_d;
      wcount_q <= wcount_d;
      first_q  <= first_d;
    end
  end

  // Next-state and counter update. enable is checked before sample_valid so
  // a drop of enable never coincides with an accept.
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    fill_d   = fill_q;
    wcount_d = wcount_q;
    first_d  = first_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StWarmup;
          warm_d  = '0;
        end
      end
      StWarmup: begin
        if (!enable) begin
          state_d = StIdle;
          warm_d  = '0;
          fill_d  = '0;
        end else if (sample_valid) begin
          warm_d = warm_q + WarmW'(1);
          if (warm_q + WarmW'(1) == WarmLast) begin
            state_d = StFill;
            fill_d  = '0;
            first_d = 1'b1;
          end
        end
      end
      StFill, StStep: begin
        if (!enable) begin
          state_d = StIdle;
          warm_d  = '0;
          fill_d  = '0;
        end else if (sample_valid) begin
          fill_d = fill_q + CNT_W'(1);
          if (fill_q + CNT_W'(1) == ((state_q == StFill) ? FillLast : StepLast)) begin
            state_d = StLatch;
          end
        end
      end
      StLatch: begin
        // One cycle covers the registered bundler latency.
        fill_d  = '0;
        state_d = StEmit;
      end
      StEmit: begin
        if (window_ready) begin
          if (wcount_q != '1) wcount_d = wcount_q + WCNT_W'(1);
          if (enable) begin
            state_d = StStep;
            first_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    sample_ready = enable & ((state_q == StWarmup) | (state_q == StFill) | (state_q == StStep));
    shift_en     = sample_valid & sample_ready;
    code_en      = shift_en & ((state_q == StFill) | (state_q == StStep));
    win_latch    = (state_q == StLatch);
    window_valid = (state_q == StEmit);
    first_win    = first_q;
    fill_cnt     = fill_q;
    window_count = wcount_q;
    state_o      = state_q;
  end

endmodule
